cp_inserter: RTL and testbench
==============================

Name: cp_inserter

Overview:
- Sits directly downstream of the IFFT core that consumes the QAM mapper's 32-sample conjugate-symmetric frames.
- Buffers each time-domain frame coming out of the IFFT.
- Emits the frame prefixed by its last CP_LEN samples (the cyclic prefix), as a continuous stream toward the DAC formatter.
- Ping-pong buffering lets one frame be written while the previous one is read.

Parameters:
W, 32, sample width (16-bit real in [31:16], 16-bit imag in [15:0]); data is passed through unmodified
FFT_LEN, 32, samples per frame (power of two)
CP_LEN, 4, cyclic prefix length; legal range 0..FFT_LEN-1
AW, 5, log2(FFT_LEN)

Ports:
aclk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
s_data_in  in  W  IFFT output sample
s_dvalid  in  1  input sample valid
s_dready  out  1  block can accept a sample
s_dlast  in  1  IFFT end-of-frame marker
m_data_out  out  W  output sample
m_dvalid  out  1  output valid
m_dready  in  1  downstream ready
m_dlast  out  1  last sample of CP+frame
err_tlast  out  1  sticky: s_dlast did not coincide with write index FFT_LEN-1
m_frame_count  out  16  frames fully emitted, wraps at 65535->0 (test visibility)

Behaviour:
- Reset: all outputs 0; both banks empty; write bank 0, read bank 0; s_dready=0 in the reset cycle, then 1 on the first clock after deassert; read FSM in IDLE. Reset mid-frame discards all buffered and partially written data.
- Storage: two banks of FFT_LEN x W (2*FFT_LEN words), each with a full flag.
- Write side:
  - A beat transfers when s_dvalid & s_dready.
  - The sample is stored at [wbank][widx], then widx increments.
  - On widx==FFT_LEN-1 the bank is marked full, widx goes to 0, and wbank toggles.
  - s_dready = !full[wbank].
  - s_dlast is checked only: if s_dlast != (widx==FFT_LEN-1) on an accepted beat, err_tlast sets and stays set until reset. Framing is always by count.
- Read FSM, states IDLE / CP / BODY:
  - IDLE -> CP when full[rbank], with ridx=FFT_LEN-CP_LEN. If CP_LEN==0, IDLE -> BODY with ridx=0.
  - CP: emit [rbank][ridx]. After emitting ridx=FFT_LEN-1, go to BODY with ridx=0.
  - BODY: emit ridx=0..FFT_LEN-1. m_dlast=1 only on ridx=FFT_LEN-1.
  - On acceptance of that last beat: clear full[rbank], toggle rbank, increment m_frame_count. Then go to CP (or BODY if CP_LEN==0) if the next bank is already full; otherwise go to IDLE.
- Output register (AXI-style):
  - m_data_out, m_dvalid and m_dlast update only when !m_dvalid | m_dready.
  - While m_dvalid & !m_dready, all three hold stable.
  - The FSM index advances only when a beat is loaded into the output register.
- Latency: last input beat of a frame accepted at edge t -> full flag visible at t+1 -> first CP sample with m_dvalid=1 at t+2 (read bank idle, m_dready=1).
- Throughput: with m_dready held high and the input keeping up, output is gapless at FFT_LEN+CP_LEN beats per frame. Input stalls (s_dready=0) only when both banks are full.
- Simultaneous events:
  - Write completing bank X in the same cycle the reader frees bank Y: both flag updates take effect.
  - Reader freeing the bank that s_dready is waiting on: s_dready rises the next cycle (registered flags, no combinational ready path from m_dready).
- Widths: indices are AW bits and wrap naturally. The CP start index FFT_LEN-CP_LEN is computed at elaboration time.

Test Plan:
- Single frame, s_data_in = k (k=0..31), m_dready=1 -> 36 beats: 28,29,30,31,0,1,...,31. m_dlast only on the beat carrying 31 after 30. First m_dvalid 2 cycles after the 32nd input beat. m_frame_count=1.
- Three back-to-back frames (values 0x100+k, 0x200+k, 0x300+k), input always valid -> 108 gapless output beats with correct CPs. s_dready drops while both banks are full, and no data is lost.
- Backpressure: m_dready toggles 1,0,0,1 repeatedly -> m_data_out, m_dvalid and m_dlast stay stable during every stall; output sequence identical to the first test.
- Framing error: s_dlast asserted at index 20 of a frame -> err_tlast=1 from the next cycle and stays set. The frame is still emitted at full length (36 beats).
- Reset asserted at output beat 10 of frame 1 while frame 2 is half written -> all outputs 0 immediately. After release, a fresh frame produces the exact sequence from the first test with no residue.
- CP_LEN=0 build -> output is 0..31 only; m_dlast on 31; latency 2 cycles.

Source files
------------

// File: rtl/cp_inserter_if.sv
// Stream bundle between the IFFT, the cyclic-prefix inserter and the DAC formatter.
// slave = inserter view, master = environment view.
interface cp_inserter_if #(parameter int W = 32);
  logic [W-1:0] s_data_in;
  logic         s_dvalid;
  logic         s_dready;
  logic         s_dlast;
  logic [W-1:0] m_data_out;
  logic         m_dvalid;
  logic         m_dready;
  logic         m_dlast;

  modport slave  (input  s_data_in, s_dvalid, s_dlast, m_dready,
                  output s_dready, m_data_out, m_dvalid, m_dlast);
  modport master (output s_data_in, s_dvalid, s_dlast, m_dready,
                  input  s_dready, m_data_out, m_dvalid, m_dlast);
endinterface

// File: rtl/cp_inserter.sv
// Ping-pong frame buffer that replays each IFFT frame prefixed by its last CP_LEN samples.
// Framing is by sample count; s_dlast is only checked and reported via err_tlast.
module cp_inserter #(
  parameter int W       = 32,
  parameter int FFT_LEN = 32,
  parameter int CP_LEN  = 4,
  parameter int AW      = 5
) (
  input  logic        aclk,
  input  logic        reset,
  cp_inserter_if.slave io,
  output logic        err_tlast,
  output logic [15:0] m_frame_count
);
  typedef enum logic [1:0] {IDLE, CP, BODY} state_e;

  localparam logic [AW-1:0] LAST     = AW'(FFT_LEN - 1);
  localparam logic [AW-1:0] RD_START = (CP_LEN == 0) ? '0 : AW'(FFT_LEN - CP_LEN);
  localparam state_e        START_ST = (CP_LEN == 0) ? BODY : CP;

  logic [W-1:0]  mem_q [2][FFT_LEN];
  logic [1:0]    full_q, full_d;
  logic          wbank_q, wbank_d, rbank_q, rbank_d;
  logic [AW-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic          rdy_q, rdy_d, err_q, err_d;
  state_e        state_q, state_d;
  logic [W-1:0]  mdata_q, mdata_d;
  logic          mvld_q, mvld_d, mlast_q, mlast_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          wr_fire, wr_done, rd_done, ld;

  assign wr_fire = io.s_dvalid & rdy_q;
  assign wr_done = wr_fire & (widx_q == LAST);
  // output register may take a new beat when empty or being drained this cycle
  assign ld      = !mvld_q | io.m_dready;

  always_ff @(posedge aclk) begin
    if (wr_fire) mem_q[wbank_q][widx_q] <= io.s_data_in;
  end

  always_comb begin
    state_d = state_q;
    ridx_d  = ridx_q;
    rbank_d = rbank_q;
    rd_done = 1'b0;
    mdata_d = mdata_q;
    mvld_d  = mvld_q;
    mlast_d = mlast_q;
    cnt_d   = cnt_q;
    if (ld) begin
      mvld_d  = 1'b0;
      mlast_d = 1'b0;
    end
    case (state_q)
      IDLE: if (full_q[rbank_q]) begin
        state_d = START_ST;
        ridx_d  = RD_START;
      end
      CP: if (ld) begin
        mdata_d = mem_q[rbank_q][ridx_q];
        mvld_d  = 1'b1;
        ridx_d  = ridx_q + AW'(1);
        if (ridx_q == LAST) state_d = BODY;
      end
      BODY: if (ld) begin
        mdata_d = mem_q[rbank_q][ridx_q];
        mvld_d  = 1'b1;
        mlast_d = (ridx_q == LAST);
        ridx_d  = ridx_q + AW'(1);
        if (ridx_q == LAST) begin
          // last word is already copied out, so the bank can be released now
          rd_done = 1'b1;
          rbank_d = ~rbank_q;
          cnt_d   = cnt_q + 16'd1;
          if (full_q[~rbank_q]) begin
            state_d = START_ST;
            ridx_d  = RD_START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wbank_q] = 1'b1;
    if (rd_done) full_d[rbank_q] = 1'b0;
    wbank_d = wbank_q ^ wr_done;
    widx_d  = wr_fire ? widx_q + AW'(1) : widx_q;
    err_d   = err_q | (wr_fire & (io.s_dlast != (widx_q == LAST)));
    // registered ready: no combinational path from m_dready to s_dready
    rdy_d   = !full_d[wbank_d];
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      widx_q  <= '0;
      ridx_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= IDLE;
      mdata_q <= '0;
      mvld_q  <= 1'b0;
      mlast_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      state_q <= state_d;
      mdata_q <= mdata_d;
      mvld_q  <= mvld_d;
      mlast_q <= mlast_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.s_dready     = rdy_q;
  assign io.m_data_out   = mdata_q;
  assign io.m_dvalid     = mvld_q;
  assign io.m_dlast      = mlast_q;
  assign err_tlast       = err_q;
  assign m_frame_count   = cnt_q;
endmodule

// File: tb/tb_cp_inserter.sv
// Directed + randomized bench for cp_inserter; expected output built from whole frames
// (CP = tail of frame, then full frame) kept in queues.
module tb_cp_inserter;
  localparam int W = 32, N = 32, AW = 5;

  logic aclk = 1'b0, reset = 1'b0;
  always #5 aclk = ~aclk;

  cp_inserter_if #(.W(W)) ifa ();
  cp_inserter_if #(.W(W)) ifb ();
  logic        err_a, err_b;
  logic [15:0] fc_a, fc_b;

  cp_inserter #(.W(W), .FFT_LEN(N), .CP_LEN(4), .AW(AW)) dut_a (
    .aclk(aclk), .reset(reset), .io(ifa), .err_tlast(err_a), .m_frame_count(fc_a));
  cp_inserter #(.W(W), .FFT_LEN(N), .CP_LEN(0), .AW(AW)) dut_b (
    .aclk(aclk), .reset(reset), .io(ifb), .err_tlast(err_b), .m_frame_count(fc_b));

  bit           sel;
  int           cp;
  logic         d_vld, d_rdy, d_last;
  logic [W-1:0] d_data;

  assign ifa.s_dvalid  = !sel ? d_vld : 1'b0;
  assign ifa.m_dready  = !sel ? d_rdy : 1'b1;
  assign ifa.s_data_in = d_data;
  assign ifa.s_dlast   = d_last;
  assign ifb.s_dvalid  = sel ? d_vld : 1'b0;
  assign ifb.m_dready  = sel ? d_rdy : 1'b1;
  assign ifb.s_data_in = d_data;
  assign ifb.s_dlast   = d_last;

  logic         o_vld, o_last, o_srdy, o_err;
  logic [W-1:0] o_data;
  logic [15:0]  o_fc;
  assign o_vld  = sel ? ifb.m_dvalid   : ifa.m_dvalid;
  assign o_last = sel ? ifb.m_dlast    : ifa.m_dlast;
  assign o_srdy = sel ? ifb.s_dready   : ifa.s_dready;
  assign o_data = sel ? ifb.m_data_out : ifa.m_data_out;
  assign o_err  = sel ? err_b : err_a;
  assign o_fc   = sel ? fc_b  : fc_a;

  int checks = 0, errors = 0;
  logic [W-1:0] inq_d[$], expq_d[$];
  logic         inq_l[$], expq_l[$];
  logic [W-1:0] frame[N];
  int  wcnt, frames_done, cyc, t_full, nfire, first_fire, last_fire, rdy_mode;
  bit  exp_err, lat_arm, saw_stall_in, rnd_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] base, input int last_at, input int n);
    for (int k = 0; k < n; k++) begin
      inq_d.push_back(base + W'(k));
      inq_l.push_back(k == last_at);
    end
  endtask

  // one clock: drive, observe handshakes before the edge, check after it
  task automatic tick();
    logic ofire, ifire, stall, pv, pl;
    logic [W-1:0] pd;
    case (rdy_mode)
      0:       d_rdy = 1'b1;
      1:       d_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: d_rdy = ($urandom % 3) != 0;
    endcase
    d_vld = (inq_d.size() > 0) && (!rnd_in || ($urandom % 4) != 0);
    d_data = d_vld ? inq_d[0] : '0;
    d_last = d_vld ? inq_l[0] : 1'b0;
    ofire = o_vld & d_rdy;
    ifire = d_vld & o_srdy;
    stall = o_vld & !d_rdy;
    pd = o_data; pv = o_vld; pl = o_last;
    if (d_vld && !o_srdy) saw_stall_in = 1'b1;
    @(posedge aclk); #1;
    cyc++;
    if (ifire) begin
      if (d_last != (wcnt == N - 1)) exp_err = 1'b1;
      frame[wcnt] = d_data;
      void'(inq_d.pop_front()); void'(inq_l.pop_front());
      wcnt++;
      if (wcnt == N) begin
        for (int k = N - cp; k < N; k++) begin expq_d.push_back(frame[k]); expq_l.push_back(1'b0); end
        for (int k = 0; k < N; k++)      begin expq_d.push_back(frame[k]); expq_l.push_back(k == N - 1); end
        wcnt = 0;
        t_full = cyc;
      end
    end
    if (ofire) begin
      chk("out_pending", expq_d.size() > 0, 1);
      if (expq_d.size() > 0) begin
        chk("out_data", pd, expq_d[0]);
        chk("out_last", pl, expq_l[0]);
        if (expq_l[0]) frames_done++;
        void'(expq_d.pop_front()); void'(expq_l.pop_front());
      end
      nfire++;
      if (nfire == 1) first_fire = cyc;
      last_fire = cyc;
    end
    if (stall) begin
      chk("stall_vld", o_vld, 1);
      chk("stall_data", o_data, pd);
      chk("stall_last", o_last, pl);
    end
    if (lat_arm && o_vld && !pv) begin
      chk("latency", cyc - t_full, 2);
      lat_arm = 1'b0;
    end
    chk("err_tlast", o_err, exp_err);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((inq_d.size() > 0 || expq_d.size() > 0) && n < budget) begin tick(); n++; end
    chk({tag, "_timeout"}, n < budget, 1);
    for (int k = 0; k < 4; k++) tick();
    chk({tag, "_frame_count"}, o_fc, 16'(frames_done));
  endtask

  task automatic do_reset();
    reset = 1'b1; d_vld = 1'b0; d_rdy = 1'b1; d_data = '0; d_last = 1'b0;
    #1;
    chk("rst_ctl_a", {ifa.m_dvalid, ifa.m_dlast, ifa.s_dready, err_a}, 0);
    chk("rst_ctl_b", {ifb.m_dvalid, ifb.m_dlast, ifb.s_dready, err_b}, 0);
    chk("rst_data", {ifa.m_data_out, ifb.m_data_out}, 0);
    chk("rst_fc", {fc_a, fc_b}, 0);
    @(posedge aclk); #1;
    reset = 1'b0;
    chk("rst_rdy_low", {ifa.s_dready, ifb.s_dready}, 0);
    @(posedge aclk); #1;
    chk("rst_rdy_high", {ifa.s_dready, ifb.s_dready}, 2'b11);
    inq_d.delete(); inq_l.delete(); expq_d.delete(); expq_l.delete();
    wcnt = 0; frames_done = 0; exp_err = 1'b0; nfire = 0; lat_arm = 1'b0;
  endtask

  initial begin
    int n;
    sel = 1'b0; cp = 4; rdy_mode = 0; rnd_in = 1'b0; cyc = 0; t_full = 0;
    saw_stall_in = 1'b0; first_fire = 0; last_fire = 0;
    do_reset();

    // single frame, latency, gapless, count
    lat_arm = 1'b1; nfire = 0;
    push_frame(32'h0, N - 1, N);
    drain("t1", 500);
    chk("t1_beats", nfire, 36);
    chk("t1_span", last_fire - first_fire, 35);
    chk("t1_lat_seen", lat_arm, 0);

    // three back-to-back frames
    nfire = 0; saw_stall_in = 1'b0;
    push_frame(32'h100, N - 1, N);
    push_frame(32'h200, N - 1, N);
    push_frame(32'h300, N - 1, N);
    drain("t2", 1000);
    chk("t2_beats", nfire, 108);
    chk("t2_span", last_fire - first_fire, 107);
    chk("t2_in_stall", saw_stall_in, 1);

    // output backpressure 1,0,0,1
    rdy_mode = 1; nfire = 0;
    push_frame(32'h0, N - 1, N);
    drain("t3", 1000);
    chk("t3_beats", nfire, 36);
    rdy_mode = 0;

    // early s_dlast
    nfire = 0;
    push_frame(32'h400, 20, N);
    drain("t4", 500);
    chk("t4_beats", nfire, 36);
    chk("t4_err", o_err, 1);

    // reset mid-output with a half-written second frame
    nfire = 0;
    push_frame(32'h500, N - 1, N);
    push_frame(32'h600, N - 1, N / 2);
    n = 0;
    while (nfire < 10 && n < 500) begin tick(); n++; end
    chk("t5_reach", nfire, 10);
    do_reset();
    lat_arm = 1'b1; nfire = 0;
    push_frame(32'h0, N - 1, N);
    drain("t5", 500);
    chk("t5_beats", nfire, 36);
    chk("t5_span", last_fire - first_fire, 35);

    // random data, random input gaps and output readiness
    rdy_mode = 2; rnd_in = 1'b1; nfire = 0;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++) begin
        inq_d.push_back($urandom);
        inq_l.push_back(k == N - 1);
      end
    drain("t7", 3000);
    chk("t7_beats", nfire, 4 * 36);
    rdy_mode = 0; rnd_in = 1'b0;

    // CP_LEN = 0 build
    sel = 1'b1; cp = 0; frames_done = 0; exp_err = 1'b0; wcnt = 0;
    lat_arm = 1'b1; nfire = 0;
    push_frame(32'h0, N - 1, N);
    drain("t6", 500);
    chk("t6_beats", nfire, 32);
    chk("t6_span", last_fire - first_fire, 31);
    chk("t6_lat_seen", lat_arm, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
